// File: rtl/decode_stage.sv
// Single-cycle instruction decode stage with valid/ready handshake on both sides.
// Optional one-entry skid buffer enabled by defining DECODE_STAGE_SKID_EN.
module decode_stage #(
    parameter int DATA_W     = 32,
    parameter int ZEXT_LOGIC = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_op,
    output logic [4:0]        out_rs,
    output logic [4:0]        out_rt,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_shamt,
    output logic [5:0]        out_funct,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_jtarget,
    output logic [1:0]        out_class,
    output logic [DATA_W-1:0] out_pc
);

    typedef struct packed {
        logic [5:0]        op;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] jtarget;
        logic [1:0]        cls;
        logic [DATA_W-1:0] pc;
    } dec_t;

    function automatic logic [DATA_W-1:0] ext_imm(input logic [5:0] op, input logic [15:0] imm);
        logic signed [15:0]       v_s;
        logic signed [DATA_W-1:0] v_se;
        v_s  = imm;
        v_se = DATA_W'(v_s);
        if ((ZEXT_LOGIC == 1) && ((op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E)))
            return {{(DATA_W-16){1'b0}}, imm};
        return v_se;
    endfunction

    function automatic logic [1:0] classify(input logic [5:0] op);
        if (op == 6'h00)
            return 2'b00;
        if ((op == 6'h02) || (op == 6'h03))
            return 2'b01;
        return 2'b10;
    endfunction

    // Upper bits come from pc+4 (modulo 2^DATA_W), low 28 bits from the index field.
    function automatic logic [DATA_W-1:0] jump_target(input logic [DATA_W-1:0] pc,
                                                      input logic [25:0]       idx);
        logic [DATA_W-1:0] v_pc4;
        v_pc4 = pc + DATA_W'(4);
        return ((v_pc4 >> 28) << 28) | DATA_W'({idx, 2'b00});
    endfunction

    logic [5:0] w_op_p0;
    dec_t       w_dec_p0;
    dec_t       r_out_p1;
    logic       r_vld_p1;
    logic       w_vld_nxt;
    logic       w_in_xfer;
    logic       w_load_in;

    // Stage p0: combinational field extraction from the incoming word
    assign w_op_p0 = in_instr[31:26];

    always_comb begin
        w_dec_p0         = '0;
        w_dec_p0.op      = w_op_p0;
        w_dec_p0.rs      = in_instr[25:21];
        w_dec_p0.rt      = in_instr[20:16];
        w_dec_p0.rd      = in_instr[15:11];
        w_dec_p0.shamt   = in_instr[10:6];
        w_dec_p0.funct   = in_instr[5:0];
        w_dec_p0.imm     = ext_imm(w_op_p0, in_instr[15:0]);
        w_dec_p0.jtarget = jump_target(in_pc, in_instr[25:0]);
        w_dec_p0.cls     = classify(w_op_p0);
        w_dec_p0.pc      = in_pc;
    end

    assign w_in_xfer = in_valid && in_ready;

`ifdef DECODE_STAGE_SKID_EN
    dec_t r_skid_p1;
    logic r_skid_vld_p1;
    logic r_rdy;
    logic w_skid_vld_nxt;
    logic w_load_skid;
    logic w_skid_to_out;

    assign in_ready = r_rdy && !flush && reset_n;

    always_comb begin
        w_vld_nxt      = r_vld_p1;
        w_skid_vld_nxt = r_skid_vld_p1;
        w_load_in      = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_out  = 1'b0;
        if (flush) begin
            w_vld_nxt      = 1'b0;
            w_skid_vld_nxt = 1'b0;
        end else if (r_skid_vld_p1) begin
            // A full skid entry implies a valid, stalled output ahead of it.
            if (out_ready) begin
                w_skid_to_out  = 1'b1;
                w_skid_vld_nxt = 1'b0;
                w_vld_nxt      = 1'b1;
            end
        end else if (!r_vld_p1 || out_ready) begin
            w_load_in = w_in_xfer;
            w_vld_nxt = w_in_xfer;
        end else if (w_in_xfer) begin
            w_load_skid    = 1'b1;
            w_skid_vld_nxt = 1'b1;
        end
    end

    // Stage p1: output and skid registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld_p1      <= 1'b0;
            r_skid_vld_p1 <= 1'b0;
            r_rdy         <= 1'b1;
            r_out_p1      <= '0;
            r_skid_p1     <= '0;
        end else begin
            r_vld_p1      <= w_vld_nxt;
            r_skid_vld_p1 <= w_skid_vld_nxt;
            r_rdy         <= !w_skid_vld_nxt;
            if (w_skid_to_out)
                r_out_p1 <= r_skid_p1;
            else if (w_load_in)
                r_out_p1 <= w_dec_p0;
            if (w_load_skid)
                r_skid_p1 <= w_dec_p0;
        end
    end
`else
    assign in_ready = (!r_vld_p1 || out_ready) && !flush && reset_n;

    always_comb begin
        w_vld_nxt = r_vld_p1;
        w_load_in = 1'b0;
        if (flush) begin
            w_vld_nxt = 1'b0;
        end else if (w_in_xfer) begin
            w_load_in = 1'b1;
            w_vld_nxt = 1'b1;
        end else if (out_ready) begin
            w_vld_nxt = 1'b0;
        end
    end

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld_p1 <= 1'b0;
            r_out_p1 <= '0;
        end else begin
            r_vld_p1 <= w_vld_nxt;
            if (w_load_in)
                r_out_p1 <= w_dec_p0;
        end
    end
`endif

    assign out_valid   = r_vld_p1;
    assign out_op      = r_out_p1.op;
    assign out_rs      = r_out_p1.rs;
    assign out_rt      = r_out_p1.rt;
    assign out_rd      = r_out_p1.rd;
    assign out_shamt   = r_out_p1.shamt;
    assign out_funct   = r_out_p1.funct;
    assign out_imm     = r_out_p1.imm;
    assign out_jtarget = r_out_p1.jtarget;
    assign out_class   = r_out_p1.cls;
    assign out_pc      = r_out_p1.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, field decode, immediates, jumps,
// backpressure, flush and reset while stalled.
module tb_decode_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_op;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [31:0] out_imm;
    logic [31:0] out_jtarget;
    logic [1:0]  out_class;
    logic [31:0] out_pc;

    int total = 0;
    int bad   = 0;

    decode_stage #(.DATA_W(32), .ZEXT_LOGIC(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
        .out_jtarget(out_jtarget), .out_class(out_class), .out_pc(out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [5:0] op, input logic [31:0] imm,
                           input logic [31:0] jt, input logic [1:0] cls, input logic [31:0] pc);
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_op"},  32'(out_op), 32'(op));
        chk({tag, "_imm"}, out_imm, imm);
        chk({tag, "_jt"},  out_jtarget, jt);
        chk({tag, "_cls"}, 32'(out_class), 32'(cls));
        chk({tag, "_pc"},  out_pc, pc);
    endtask

    task automatic apply(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h012A4020;
        in_pc     = 32'h0040_0000;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles with valid input pending
        tick();
        tick();
        chk("rst_vld",   32'(out_valid), 32'd0);
        chk("rst_rdy",   32'(in_ready), 32'd0);
        chk("rst_op",    32'(out_op), 32'd0);
        chk("rst_rs",    32'(out_rs), 32'd0);
        chk("rst_rd",    32'(out_rd), 32'd0);
        chk("rst_funct", 32'(out_funct), 32'd0);
        chk("rst_imm",   out_imm, 32'd0);
        chk("rst_jt",    out_jtarget, 32'd0);
        chk("rst_cls",   32'(out_class), 32'd0);
        chk("rst_pc",    out_pc, 32'd0);

        // R-type
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("idle_rdy", 32'(in_ready), 32'd1);
        apply(32'h012A4020, 32'h0040_0000);
        chk_vec("rtype", 6'h00, 32'h0000_4020, 32'h04A9_0080, 2'b00, 32'h0040_0000);
        chk("rtype_rs",    32'(out_rs), 32'd9);
        chk("rtype_rt",    32'(out_rt), 32'd10);
        chk("rtype_rd",    32'(out_rd), 32'd8);
        chk("rtype_shamt", 32'(out_shamt), 32'd0);
        chk("rtype_funct", 32'(out_funct), 32'h20);

        // Immediates: sign vs zero extension at the opcode boundaries
        apply(32'h2128FFFC, 32'h0040_0010);
        chk_vec("addi", 6'h08, 32'hFFFF_FFFC, 32'h04A3_FFF0, 2'b10, 32'h0040_0010);
        apply(32'h3528FFFC, 32'h0040_0014);
        chk_vec("ori",  6'h0D, 32'h0000_FFFC, 32'h04A3_FFF0, 2'b10, 32'h0040_0014);
        apply(32'h3128FFFC, 32'h0040_0018);
        chk_vec("andi", 6'h0C, 32'h0000_FFFC, 32'h04A3_FFF0, 2'b10, 32'h0040_0018);
        apply(32'h3928FFFC, 32'h0040_001C);
        chk_vec("xori", 6'h0E, 32'h0000_FFFC, 32'h04A3_FFF0, 2'b10, 32'h0040_001C);
        apply(32'h3D28FFFC, 32'h0040_0020);
        chk_vec("lui",  6'h0F, 32'hFFFF_FFFC, 32'h04A3_FFF0, 2'b10, 32'h0040_0020);
        apply(32'h2928FFFC, 32'h0040_0024);
        chk_vec("slti", 6'h0A, 32'hFFFF_FFFC, 32'h04A3_FFF0, 2'b10, 32'h0040_0024);
        apply(32'h04000000, 32'h0000_0000);
        chk_vec("op1",  6'h01, 32'h0000_0000, 32'h0000_0000, 2'b10, 32'h0000_0000);

        // Jumps, including pc+4 wrap
        apply(32'h08000010, 32'hF000_0000);
        chk_vec("j",    6'h02, 32'h0000_0010, 32'hF000_0040, 2'b01, 32'hF000_0000);
        apply(32'h0C000010, 32'hFFFF_FFFC);
        chk_vec("jal",  6'h03, 32'h0000_0010, 32'h0000_0040, 2'b01, 32'hFFFF_FFFC);

        in_valid = 1'b0;
        tick();
        chk("drain_vld", 32'(out_valid), 32'd0);

        // Backpressure: A then B while out_ready=0
        out_ready = 1'b0;
        apply(32'h012A4020, 32'h0000_0100);
        chk("bpA_vld", 32'(out_valid), 32'd1);
        chk("bpA_pc",  out_pc, 32'h0000_0100);
        in_instr = 32'h2128FFFC;
        in_pc    = 32'h0000_0104;
        #1;
`ifdef DECODE_STAGE_SKID_EN
        chk("bpB_rdy", 32'(in_ready), 32'd1);
`else
        chk("bpB_rdy", 32'(in_ready), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
`ifdef DECODE_STAGE_SKID_EN
            in_valid = 1'b0;
`endif
            chk("bp_hold_vld", 32'(out_valid), 32'd1);
            chk("bp_hold_pc",  out_pc, 32'h0000_0100);
            chk("bp_hold_op",  32'(out_op), 32'h00);
            chk("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk_vec("bpB", 6'h08, 32'hFFFF_FFFC, 32'h04A3_FFF0, 2'b10, 32'h0000_0104);
        in_valid = 1'b0;
        tick();
        chk("bp_end_vld", 32'(out_valid), 32'd0);

        // Flush with valid output and pending input
        out_ready = 1'b0;
        apply(32'h3528FFFC, 32'h0000_0200);
        chk("fl_pre_vld", 32'(out_valid), 32'd1);
        flush    = 1'b1;
        in_instr = 32'h08000010;
        in_pc    = 32'h0000_0204;
        #1;
        chk("fl_rdy", 32'(in_ready), 32'd0);
        tick();
        chk("fl_vld", 32'(out_valid), 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("fl_post_vld", 32'(out_valid), 32'd0);
        chk("fl_post_rdy", 32'(in_ready), 32'd1);

        // Reset while stalled discards both held instructions
        apply(32'h012A4020, 32'h0000_0300);
        apply(32'h2128FFFC, 32'h0000_0304);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        chk("rs_vld", 32'(out_valid), 32'd0);
        chk("rs_pc",  out_pc, 32'd0);
        chk("rs_rdy", 32'(in_ready), 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("rs_post_vld", 32'(out_valid), 32'd0);
        chk("rs_post_rdy", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, giving the datapath width of pc, immediate and jump-target values; legal values are 32 and above.
REQ-002 SHALL provide parameter ZEXT_LOGIC, default 1; when 1, opcodes 0x0C, 0x0D and 0x0E zero-extend the immediate.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port list (name, direction, width, meaning):
  - clk  in  1  clock; all state updates on the rising edge.
  - reset_n  in  1  synchronous active-low reset.
  - in_valid  in  1  upstream instruction valid.
  - in_ready  out  1  stage can accept an instruction.
  - in_instr  in  32  instruction word.
  - in_pc  in  DATA_W  address of in_instr.
  - flush  in  1  discard all held instructions.
  - out_valid  out  1  decoded instruction valid.
  - out_ready  in  1  downstream accepts.
  - out_op  out  6  instr[31:26].
  - out_rs  out  5  instr[25:21].
  - out_rt  out  5  instr[20:16].
  - out_rd  out  5  instr[15:11].
  - out_shamt  out  5  instr[10:6].
  - out_funct  out  6  instr[5:0].
  - out_imm  out  DATA_W  extended instr[15:0].
  - out_jtarget  out  DATA_W  jump target.
  - out_class  out  2  00 = R, 01 = J, 10 = I.
  - out_pc  out  DATA_W  pc of the decoded instruction.

Function
REQ-005 An input transfer occurs on a rising edge with in_valid && in_ready; an output transfer occurs on a rising edge with out_valid && out_ready.
REQ-006 Latency is one cycle: an instruction accepted at edge N is visible on the outputs, with out_valid=1, after edge N.
REQ-007 All out_* fields and out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-008 out_imm SHALL be the zero-extension of instr[15:0] when ZEXT_LOGIC=1 and op is 0x0C, 0x0D or 0x0E; otherwise it is the sign-extension (bit 15 replicated up to DATA_W).
REQ-009 out_jtarget SHALL be {(in_pc+4)[DATA_W-1:28], instr[25:0], 2'b00}; in_pc+4 wraps modulo 2^DATA_W.
REQ-010 out_class SHALL be 00 when op=0, 01 when op is 2 or 3, and 10 otherwise.
REQ-011 Without the skid buffer, in_ready SHALL equal (!out_valid || out_ready) && !flush && reset_n.
REQ-012 flush=1 at an edge SHALL clear out_valid and the skid buffer; no input is accepted in that cycle (in_ready=0).
REQ-013 Instruction order is preserved; no instruction is lost or duplicated; sustained throughput is one instruction per cycle when out_ready=1.
REQ-014 A simultaneous output transfer and input transfer in the same cycle SHALL replace the output contents with the new instruction, keeping out_valid=1.

Reset
REQ-015 While reset_n=0 at an edge: out_valid=0, the skid buffer is empty, and all out_* data fields are 0.
REQ-016 in_ready=0 while reset_n=0.
REQ-017 Reset asserted mid-stall SHALL discard all held instructions.

Configuration
REQ-018 Macro DECODE_STAGE_SKID_EN SHALL control the skid buffer.
  - When defined: a one-entry skid buffer is added; in_ready is driven from a register and equals skid-empty && !flush.
  - When defined: an input accepted while the output is stalled is stored in the skid buffer and moves to the output on the next output transfer.
  - When undefined: no skid buffer is present; REQ-011 applies.

Verification
REQ-019 Reset: reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, all fields 0, in_ready=0.
REQ-020 R-type: in_instr=0x012A4020, in_pc=0x00400000 -> next cycle op=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20, class=00.
REQ-021 Immediates:
  - 0x2128FFFC -> out_imm=0xFFFFFFFC, class=10.
  - 0x3528FFFC with ZEXT_LOGIC=1 -> out_imm=0x0000FFFC.
REQ-022 Jump: in_instr=0x08000010, in_pc=0xF0000000 -> out_jtarget=0xF0000040, class=01.
REQ-023 Backpressure: hold out_ready=0 for 3 cycles while presenting instructions A then B.
  - Outputs stay A throughout.
  - B is held in the skid buffer (macro defined) or refused with in_ready=0 (macro undefined).
  - After out_ready=1: A then B are delivered on consecutive transfers.
REQ-024 Flush: flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, and the input is not accepted.
